// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N_CH-to-1 channel multiplexer with two modes.
// Manual mode follows the S select every cycle. Auto-scan mode walks the
// channels 0..N_CH-1, holding each one for DWELL cycles, and pulses
// frame_done on the final sample of every full frame.
module mux_scan_seq #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] I,
    input  logic [SW-1:0]     S,
    input  logic              mode,
    input  logic              start,
    output logic [W-1:0]      F,
    output logic [SW-1:0]     ch,
    output logic              valid,
    output logic              frame_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Last channel index and last dwell count, sized to their counters.
    localparam logic [SW-1:0] LAST_CH    = SW'(N_CH - 1);
    localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);

    state_t          state_reg, state_next;
    logic [SW-1:0]   cnt_reg, cnt_next;
    logic [7:0]      dcnt_reg, dcnt_next;
    logic [W-1:0]    f_reg, f_next;
    logic [SW-1:0]   ch_reg, ch_next;
    logic            valid_reg, valid_next;
    logic            fd_reg, fd_next;

    // Unpack the flat channel bus so both select paths index one array.
    logic [W-1:0] chan_data [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign chan_data[gi] = I[gi*W +: W];
        end
    endgenerate

    // Next-state and next-output logic; manual mode overrides the FSM.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dcnt_next  = dcnt_reg;
        f_next     = f_reg;
        ch_next    = ch_reg;
        valid_next = 1'b0;
        fd_next    = 1'b0;

        if (!mode) begin
            // Manual select: forces the scan machinery back to rest.
            state_next = IDLE;
            cnt_next   = '0;
            dcnt_next  = '0;
            f_next     = chan_data[S];
            ch_next    = S;
            valid_next = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // F/ch hold their last values while waiting for start.
                    if (start) begin
                        state_next = SCAN;
                        cnt_next   = '0;
                        dcnt_next  = '0;
                    end
                end
                SCAN: begin
                    // Data is sampled live, so F follows I during a dwell.
                    f_next     = chan_data[cnt_reg];
                    ch_next    = cnt_reg;
                    valid_next = 1'b1;
                    fd_next    = (cnt_reg == LAST_CH) && (dcnt_reg == DWELL_LAST);
                    if (dcnt_reg == DWELL_LAST) begin
                        dcnt_next = '0;
                        // N_CH is a power of two, so the counter wraps naturally.
                        cnt_next  = cnt_reg + SW'(1);
                    end else begin
                        dcnt_next = dcnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dcnt_reg  <= '0;
            f_reg     <= '0;
            ch_reg    <= '0;
            valid_reg <= 1'b0;
            fd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dcnt_reg  <= dcnt_next;
            f_reg     <= f_next;
            ch_reg    <= ch_next;
            valid_reg <= valid_next;
            fd_reg    <= fd_next;
        end
    end

    assign F          = f_reg;
    assign ch         = ch_reg;
    assign valid      = valid_reg;
    assign frame_done = fd_reg;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Testbench for mux_scan_seq: two instances (16x1 dwell 1, 4x4 dwell 3)
// checked by a table of vectors, directed corner sequences and a random run
// against a sample-count reference model.
module tb_mux_scan_seq;

    logic        clk;
    logic        rst;

    logic [15:0] i16;
    logic [3:0]  s16;
    logic        mode16, start16;
    logic [0:0]  f16;
    logic [3:0]  ch16;
    logic        v16, fd16;

    logic [15:0] i4;
    logic [1:0]  s4;
    logic        mode4, start4;
    logic [3:0]  f4;
    logic [1:0]  ch4;
    logic        v4, fd4;

    int n_checks = 0;
    int n_fail   = 0;

    mux_scan_seq #(.N_CH(16), .W(1), .DWELL(1)) dut16 (
        .clk(clk), .rst(rst), .I(i16), .S(s16), .mode(mode16), .start(start16),
        .F(f16), .ch(ch16), .valid(v16), .frame_done(fd16)
    );

    mux_scan_seq #(.N_CH(4), .W(4), .DWELL(3)) dut4 (
        .clk(clk), .rst(rst), .I(i4), .S(s4), .mode(mode4), .start(start4),
        .F(f4), .ch(ch4), .valid(v4), .frame_done(fd4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: scanning is described by the sample number k since
    // start; channel and frame position follow from plain division.
    typedef struct {
        bit scan;
        int k;
        int f;
        int ch;
        bit v;
        bit fd;
    } model_t;

    model_t m16, m4;

    function automatic int chv(int iv, int w, int c);
        return (iv >> (c * w)) & ((1 << w) - 1);
    endfunction

    function automatic model_t step(model_t m, int n, int w, int d,
                                    int iv, int s, logic md, logic st);
        model_t r;
        int c;
        r = m;
        r.fd = 1'b0;
        if (!md) begin
            r.scan = 1'b0;
            r.f    = chv(iv, w, s);
            r.ch   = s;
            r.v    = 1'b1;
        end else if (!m.scan) begin
            r.v = 1'b0;
            if (st) begin
                r.scan = 1'b1;
                r.k    = 0;
            end
        end else begin
            c      = (m.k / d) % n;
            r.ch   = c;
            r.f    = chv(iv, w, c);
            r.v    = 1'b1;
            r.fd   = ((m.k % (n * d)) == (n * d - 1));
            r.k    = m.k + 1;
        end
        return r;
    endfunction

    function automatic model_t zero_model();
        model_t r;
        r.scan = 1'b0;
        r.k    = 0;
        r.f    = 0;
        r.ch   = 0;
        r.v    = 1'b0;
        r.fd   = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance both models with the current inputs, clock, compare.
    task automatic tick();
        m16 = step(m16, 16, 1, 1, int'(i16), int'(s16), mode16, start16);
        m4  = step(m4, 4, 4, 3, int'(i4), int'(s4), mode4, start4);
        @(posedge clk);
        #1;
        check("d16_F",  32'(f16),  32'(m16.f));
        check("d16_ch", 32'(ch16), 32'(m16.ch));
        check("d16_v",  32'(v16),  32'(m16.v));
        check("d16_fd", 32'(fd16), 32'(m16.fd));
        check("d4_F",   32'(f4),   32'(m4.f));
        check("d4_ch",  32'(ch4),  32'(m4.ch));
        check("d4_v",   32'(v4),   32'(m4.v));
        check("d4_fd",  32'(fd4),  32'(m4.fd));
        $display("t=%0t d16 ch=%0d F=%0h v=%0b fd=%0b | d4 ch=%0d F=%0h v=%0b fd=%0b",
                 $time, ch16, f16, v16, fd16, ch4, f4, v4, fd4);
    endtask

    // Pulse reset between clock edges and check the immediate clear.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_F16"},  32'(f16),  32'd0);
        check({tag, "_ch16"}, 32'(ch16), 32'd0);
        check({tag, "_v16"},  32'(v16),  32'd0);
        check({tag, "_fd16"}, 32'(fd16), 32'd0);
        check({tag, "_F4"},   32'(f4),   32'd0);
        check({tag, "_v4"},   32'(v4),   32'd0);
        m16 = zero_model();
        m4  = zero_model();
        @(negedge clk);
        rst = 1'b0;
        $display("t=%0t async reset pulse (%s)", $time, tag);
    endtask

    // Advance dut16 until it shows channel c; an expired bound is a failure.
    task automatic wait_ch16(input int c, input string name);
        int n;
        n = 0;
        while (ch16 !== 4'(c) && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(ch16), 32'(c));
    endtask

    typedef struct {
        bit          tgt4;
        logic [15:0] i;
        logic [3:0]  s;
        logic        mode;
        logic        start;
        logic [3:0]  ef;
        logic [3:0]  ech;
        logic        ev;
        logic        efd;
    } vec_t;

    localparam int NVEC = 46;
    vec_t vecs [NVEC];
    int   nib  [4];
    logic [15:0] saved_i;

    initial begin
        // Table: dwell-3 scan on the 4x4 instance, then the one-hot manual walk.
        nib[0] = 4'h3; nib[1] = 4'hC; nib[2] = 4'h5; nib[3] = 4'hA;
        for (int j = 0; j < 14; j++) begin
            vecs[j].tgt4  = 1'b1;
            vecs[j].i     = 16'hA5C3;
            vecs[j].s     = 4'd0;
            vecs[j].mode  = 1'b1;
            vecs[j].start = (j == 0);
            if (j == 0) begin
                vecs[j].ef  = 4'h0;
                vecs[j].ech = 4'd0;
                vecs[j].ev  = 1'b0;
                vecs[j].efd = 1'b0;
            end else begin
                vecs[j].ech = 4'(((j - 1) / 3) % 4);
                vecs[j].ef  = 4'(nib[((j - 1) / 3) % 4]);
                vecs[j].ev  = 1'b1;
                vecs[j].efd = (j == 12);
            end
        end
        for (int k = 0; k < 16; k++) begin
            for (int h = 0; h < 2; h++) begin
                int r;
                r = 14 + 2 * k + h;
                vecs[r].tgt4  = 1'b0;
                vecs[r].i     = 16'd1 << k;
                vecs[r].s     = 4'((k + h) % 16);
                vecs[r].mode  = 1'b0;
                vecs[r].start = 1'b0;
                vecs[r].ef    = (h == 0) ? 4'd1 : 4'd0;
                vecs[r].ech   = 4'((k + h) % 16);
                vecs[r].ev    = 1'b1;
                vecs[r].efd   = 1'b0;
            end
        end

        i16 = '0; s16 = '0; mode16 = 1'b0; start16 = 1'b0;
        i4  = '0; s4  = '0; mode4  = 1'b1; start4  = 1'b0;
        m16 = zero_model();
        m4  = zero_model();

        // Reset state.
        rst = 1'b1;
        #1;
        check("rst_F16",  32'(f16),  32'd0);
        check("rst_ch16", 32'(ch16), 32'd0);
        check("rst_v16",  32'(v16),  32'd0);
        check("rst_fd16", 32'(fd16), 32'd0);
        check("rst_F4",   32'(f4),   32'd0);
        check("rst_v4",   32'(v4),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int j = 0; j < NVEC; j++) begin
            if (vecs[j].tgt4) begin
                i4 = vecs[j].i; s4 = vecs[j].s[1:0];
                mode4 = vecs[j].mode; start4 = vecs[j].start;
            end else begin
                i16 = vecs[j].i; s16 = vecs[j].s;
                mode16 = vecs[j].mode; start16 = vecs[j].start;
            end
            tick();
            if (vecs[j].tgt4) begin
                check($sformatf("vec%0d_F", j),  32'(f4),  32'(vecs[j].ef));
                check($sformatf("vec%0d_ch", j), 32'(ch4), 32'(vecs[j].ech));
                check($sformatf("vec%0d_v", j),  32'(v4),  32'(vecs[j].ev));
                check($sformatf("vec%0d_fd", j), 32'(fd4), 32'(vecs[j].efd));
            end else begin
                check($sformatf("vec%0d_F", j),  32'(f16),  32'(vecs[j].ef));
                check($sformatf("vec%0d_ch", j), 32'(ch16), 32'(vecs[j].ech));
                check($sformatf("vec%0d_v", j),  32'(v16),  32'(vecs[j].ev));
                check($sformatf("vec%0d_fd", j), 32'(fd16), 32'(vecs[j].efd));
            end
        end

        // Auto-scan, dwell 1: two frames from a single start pulse.
        i16 = 16'h8001; mode16 = 1'b1; start16 = 1'b1;
        tick();
        check("scan_start_v", 32'(v16), 32'd0);
        start16 = 1'b0;
        for (int j = 0; j < 32; j++) begin
            tick();
            check("scan_ch", 32'(ch16), 32'(j % 16));
            check("scan_F",  32'(f16),  32'((j % 16 == 0) || (j % 16 == 15)));
            check("scan_fd", 32'(fd16), 32'(j % 16 == 15));
        end

        // Start during scan is ignored.
        wait_ch16(4, "wait_ch4");
        start16 = 1'b1;
        tick();
        check("ign_start_ch5", 32'(ch16), 32'd5);
        start16 = 1'b0;
        tick();
        check("ign_start_ch6", 32'(ch16), 32'd6);
        check("ign_start_v",   32'(v16),  32'd1);

        // Abort to manual mid-frame, then re-raise mode without start.
        wait_ch16(7, "wait_ch7");
        saved_i = 16'($urandom);
        mode16 = 1'b0; s16 = 4'd2; i16 = saved_i;
        tick();
        check("abort_ch", 32'(ch16), 32'd2);
        check("abort_F",  32'(f16),  32'(saved_i[2]));
        check("abort_v",  32'(v16),  32'd1);
        check("abort_fd", 32'(fd16), 32'd0);
        mode16 = 1'b1;
        tick();
        check("rearm_v0", 32'(v16), 32'd0);
        tick();
        check("rearm_v1", 32'(v16), 32'd0);

        // Asynchronous reset mid-scan, then no restart without start.
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_ch16(9, "wait_ch9");
        async_reset("arst");
        for (int j = 0; j < 3; j++) begin
            tick();
            check("post_rst_v", 32'(v16), 32'd0);
        end

        // Random run against the model.
        for (int n = 0; n < 600; n++) begin
            mode16  = ($urandom_range(0, 9) != 0);
            start16 = ($urandom_range(0, 7) == 0);
            s16     = 4'($urandom_range(0, 15));
            i16     = 16'($urandom);
            mode4   = ($urandom_range(0, 19) != 0);
            start4  = ($urandom_range(0, 5) == 0);
            s4      = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) i4 = 16'($urandom);
            tick();
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 Parameter N_CH, default 16, number of input channels; power of two, 2..256.
REQ-002 Parameter W, default 1, data width per channel in bits.
REQ-003 Parameter DWELL, default 1, cycles each channel is held in auto-scan; range 1..255.
REQ-004 Derived SW = log2(N_CH), select/channel-index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 I  input  N_CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 S  input  SW  manual channel select.
REQ-009 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-010 start  input  1  single-cycle request to begin auto-scan.
REQ-011 F  output  W  registered selected data.
REQ-012 ch  output  SW  index of the channel currently driven on F.
REQ-013 valid  output  1  F/ch hold a freshly sampled channel.
REQ-014 frame_done  output  1  single-cycle pulse on the last sample of a full scan frame.

Function
REQ-015 States SHALL be IDLE and SCAN; internal channel counter cnt (SW bits) and dwell counter dcnt (8 bits).
REQ-016 Manual mode (mode=0): every cycle F <= I[S], ch <= S, valid <= 1, frame_done <= 0; latency exactly one clock from S/I to F.
REQ-017 Manual mode SHALL force state IDLE, cnt=0, dcnt=0; start ignored.
REQ-018 IDLE with mode=1: F and ch hold, valid <= 0, frame_done <= 0.
REQ-019 IDLE with mode=1 and start=1: next state SCAN, cnt=0, dcnt=0; first sample (channel 0) appears on F one cycle after entering SCAN.
REQ-020 SCAN: each cycle F <= I[cnt], ch <= cnt, valid <= 1; I sampled live every cycle, so F tracks I changes during dwell.
REQ-021 SCAN: dcnt increments each cycle; when dcnt = DWELL-1, dcnt <= 0 and cnt <= cnt+1, with wrap from N_CH-1 to 0.
REQ-022 frame_done SHALL be 1 in the same cycle F shows the last dwell sample of channel N_CH-1, else 0.
REQ-023 Scan SHALL run continuously, frame after frame, while mode=1; start during SCAN is ignored.
REQ-024 mode 1->0 during SCAN: abort at next edge to manual behaviour (REQ-016/017); no frame_done issued for the partial frame.
REQ-025 mode 0->1: enter IDLE; valid drops to 0 one cycle later; scan requires a new start.
REQ-026 DWELL=1: channel advances every cycle; a frame is exactly N_CH*DWELL cycles.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, set F=0, ch=0, valid=0, frame_done=0, state IDLE, cnt=0, dcnt=0.
REQ-028 Reset mid-scan SHALL discard progress; after release, scan resumes only on a new start with mode=1.
REQ-029 First active edge after rst deasserts SHALL obey REQ-016..019 normally.

Verification (N_CH=16, W=1 unless stated)
REQ-030 Manual one-hot walk: for k=0..15 drive I=1<<k, S=k, each held 1 cycle -> F=1, ch=k one cycle later; repeat with S=(k+1)%16 -> F=0.
REQ-031 Auto-scan, DWELL=1: I=16'h8001, mode=1, start pulse -> F sequence 1,0x14,1 over ch 0..15; frame_done only at ch=15; second frame repeats without a new start.
REQ-032 DWELL=3, W=4, N_CH=4, I=16'hA5C3: ch 0,0,0,1,1,1,2,2,2,3,3,3 with F=3,3,3,C,C,C,5,5,5,A,A,A; frame_done on 12th sample only.
REQ-033 Abort: mode drops to 0 at ch=7 mid-frame with S=2 -> next cycle ch=2, F=I[2], valid=1, no frame_done; re-raise mode -> valid=0 until new start.
REQ-034 Async reset: assert rst between clock edges at ch=9 -> F, ch, valid, frame_done zero immediately; after release with mode=1 and no start, valid stays 0.
REQ-035 Start ignored: pulse start at ch=4 during SCAN -> sequence continues 5,6,... uninterrupted.
